// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings for the multiply/divide unit.
// Holds the op encoding, the sequencer state set and the iteration count.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MULTU = 3'd0,
        OP_MULT  = 3'd1,
        OP_DIVU  = 3'd2,
        OP_DIV   = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } mdu_op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } mdu_state_t;

    localparam int MDU_ITERATIONS = 32;

endpackage

// File: rtl/mdu_shift_core.sv
// mdu_shift_core: 64-bit accumulator with one-bit-per-step datapath,
// shared by shift-add multiply and restoring division.
module mdu_shift_core
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0]   m_in,
    output logic [2*WIDTH-1:0] acc
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     trial;

    always_comb begin
        acc_d = acc_q;
        m_d   = m_q;
        sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, m_q};
        // shifted partial remainder minus divisor; bit WIDTH is the borrow
        trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, m_q};
        if (load) begin
            acc_d = load_val;
            m_d   = m_in;
        end else if (step) begin
            if (is_div) begin
                if (!trial[WIDTH]) begin
                    acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
                end
            end else if (acc_q[0]) begin
                acc_d = {sum, acc_q[WIDTH-1:1]};
            end else begin
                acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            acc_q <= '0;
            m_q   <= '0;
        end else begin
            acc_q <= acc_d;
            m_q   <= m_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative MULT/DIV sequencer owning the HI/LO registers.
// Define MDU_SIGNED_EN to make ops MULT/DIV signed; otherwise they are unsigned.
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dz
);

    localparam logic [4:0] LAST_CNT = 5'(MDU_ITERATIONS - 1);

    mdu_state_t         state_q, state_d;
    mdu_op_t            op_e;
    logic [4:0]         cnt_q, cnt_d;
    logic               prime_q, prime_d;
    logic               zero_q, zero_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               core_load, core_step;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   res_hi, res_lo;

    assign op_e = mdu_op_t'(op);

`ifdef MDU_SIGNED_EN
    logic               sgn_op, a_neg, b_neg;
    logic               div_q, div_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic [2*WIDTH-1:0] prod_fix;

    assign sgn_op = (op_e == OP_MULT) || (op_e == OP_DIV);
    assign a_neg  = sgn_op & a[WIDTH-1];
    assign b_neg  = sgn_op & b[WIDTH-1];
    assign a_mag  = a_neg ? -a : a;
    assign b_mag  = b_neg ? -b : b;

    // divide-by-zero keeps the all-ones quotient unsigned
    assign prod_fix = qneg_q ? -acc : acc;
    assign res_hi = div_q ? (rneg_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH])
                          : prod_fix[2*WIDTH-1:WIDTH];
    assign res_lo = div_q ? ((qneg_q && !zero_q) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0])
                          : prod_fix[WIDTH-1:0];
`else
    assign a_mag  = a;
    assign b_mag  = b;
    assign res_hi = acc[2*WIDTH-1:WIDTH];
    assign res_lo = acc[WIDTH-1:0];
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prime_d   = 1'b0;
        zero_d    = zero_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        core_load = 1'b0;
        core_step = 1'b0;
`ifdef MDU_SIGNED_EN
        div_d     = div_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    unique case (op_e)
                        OP_MULTU, OP_MULT, OP_DIVU, OP_DIV: begin
                            state_d   = op[1] ? S_DIV : S_MUL;
                            core_load = 1'b1;
                            prime_d   = 1'b1;
                            cnt_d     = '0;
                            dz_d      = 1'b0;
                            zero_d    = op[1] && (b == '0);
`ifdef MDU_SIGNED_EN
                            div_d     = op[1];
                            qneg_d    = a_neg ^ b_neg;
                            rneg_d    = a_neg;
`endif
                        end
                        OP_MTHI: begin
                            hi_d = a;
                            dz_d = 1'b0;
                        end
                        OP_MTLO: begin
                            lo_d = a;
                            dz_d = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL, S_DIV: begin
                // first cycle after acceptance lets the loaded operands settle
                if (!prime_q) begin
                    core_step = 1'b1;
                    cnt_d     = cnt_q + 5'd1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                hi_d    = res_hi;
                lo_d    = res_lo;
                dz_d    = zero_q;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            prime_q <= 1'b0;
            zero_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef MDU_SIGNED_EN
            div_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prime_q <= prime_d;
            zero_q  <= zero_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef MDU_SIGNED_EN
            div_q   <= div_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
`endif
        end
    end

    mdu_shift_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clock    (clock),
        .reset    (reset),
        .load     (core_load),
        .step     (core_step),
        .is_div   (state_q == S_DIV),
        .load_val ({{WIDTH{1'b0}}, a_mag}),
        .m_in     (b_mag),
        .acc      (acc)
    );

    assign busy = (state_q != S_IDLE) && !prime_q;
    assign done = (state_q == S_DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;
    assign dz   = dz_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: scoreboard bench for mdu_sequencer with an
// arithmetic reference model; honours MDU_SIGNED_EN like the design.
module tb_mdu_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, dz;
    logic [31:0] hi, lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          bstart = 1;
    int          bend = 0;
    int          idle_from = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic        m_dz = 1'b0;
    bit          run = 1'b0;

    mdu_sequencer #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo),
        .dz    (dz)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] o, input logic [31:0] x,
                                   input logic [31:0] y, input int c);
        exp_t   r;
        longint sx, sy, p;
        bit     sgn;
        sgn = 1'b0;
`ifdef MDU_SIGNED_EN
        sgn = (o == 3'd1) || (o == 3'd3);
`endif
        sx = sgn ? longint'($signed(x)) : longint'({32'd0, x});
        sy = sgn ? longint'($signed(y)) : longint'({32'd0, y});
        r.cyc = c;
        r.dz  = 1'b0;
        if (o <= 3'd1) begin
            p    = sx * sy;
            r.hi = p[63:32];
            r.lo = p[31:0];
        end else if (y == 32'd0) begin
            r.hi = x;
            r.lo = 32'hFFFF_FFFF;
            r.dz = 1'b1;
        end else begin
            p    = sx / sy;
            r.lo = p[31:0];
            p    = sx % sy;
            r.hi = p[31:0];
        end
        return r;
    endfunction

    // monitor: per-cycle register/busy checks and done-time scoreboard pops
    always @(negedge clock) begin
        exp_t e;
        if (run) begin
            chk("busy", 64'(busy), 64'(cyc >= bstart && cyc <= bend));
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(e.cyc));
                    m_hi = e.hi;
                    m_lo = e.lo;
                    m_dz = e.dz;
                end
            end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                chk("missing_done", 64'(done), 64'd1);
                void'(sb.pop_front());
            end
            chk("hi", 64'(hi), 64'(m_hi));
            chk("lo", 64'(lo), 64'(m_lo));
            chk("dz", 64'(dz), 64'(m_dz));
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        int e;
        @(negedge clock);
        #1;
        e = cyc + 1;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (e >= idle_from) begin
            if (o <= 3'd3) begin
                sb.push_back(model(o, x, y, e + 34));
                bstart    = e + 1;
                bend      = e + 34;
                idle_from = e + 36;
                m_dz      = 1'b0;
            end else if (o == 3'd4) begin
                m_hi = x;
                m_dz = 1'b0;
            end else if (o == 3'd5) begin
                m_lo = x;
                m_dz = 1'b0;
            end
        end
    endtask

    task automatic quiet(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
            start = 1'b0;
            op    = 3'($urandom);
            a     = $urandom;
            b     = $urandom;
        end
    endtask

    task automatic do_reset(input bit with_start);
        @(negedge clock);
        #1;
        reset = 1'b0;
        start = with_start;
        op    = 3'd4;
        a     = 32'hDEAD_BEEF;
        sb.delete();
        m_hi      = '0;
        m_lo      = '0;
        m_dz      = 1'b0;
        bend      = 0;
        idle_from = cyc + 2;
        @(negedge clock);
        #1;
        reset = 1'b1;
        start = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'd0;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000;
            3:       v = $urandom_range(0, 15);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        reset = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        run = 1'b1;
        @(negedge clock);
        #1;
        reset     = 1'b1;
        idle_from = cyc + 1;

        issue(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        quiet(40);
        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        quiet(40);
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        quiet(40);
        issue(3'd1, 32'hFFFF_FFFD, 32'd7);
        quiet(40);
        issue(3'd2, 32'd100, 32'd0);
        quiet(40);
        issue(3'd5, 32'd5, 32'd0);
        quiet(3);
        issue(3'd3, 32'h8000_0005, 32'd0);
        quiet(40);
        issue(3'd7, 32'h1111_1111, 32'd1);
        issue(3'd6, 32'h2222_2222, 32'd1);
        quiet(3);
        issue(3'd1, 32'd3, 32'd4);
        quiet(9);
        issue(3'd2, 32'd9, 32'd3);
        quiet(40);
        issue(3'd2, 32'd50, 32'd7);
        quiet(19);
        do_reset(1'b0);
        quiet(40);
        issue(3'd4, 32'h0000_1234, 32'd0);
        issue(3'd0, 32'd2, 32'd3);
        quiet(40);
        do_reset(1'b1);
        quiet(3);

        for (int i = 0; i < 40; i++) begin
            issue(3'($urandom_range(0, 7)), pick(), pick());
            quiet($urandom_range(0, 40));
        end
        quiet(45);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_sequencer.md
MDU_SEQUENCER -- requirements
Module: mdu_sequencer

Interface
REQ-001 Parameter: WIDTH, 32, operand/HI/LO width; the design SHALL support only 32.
REQ-002 clock  in  1  single rising-edge clock for all state.
REQ-003 reset  in  1  synchronous, active-low reset, sampled on the clock rising edge.
REQ-004 start  in  1  one-cycle request, accepted only in IDLE.
REQ-005 op  in  3  0=MULTU, 1=MULT, 2=DIVU, 3=DIV, 4=MTHI, 5=MTLO, 6-7 reserved.
REQ-006 a  in  WIDTH  multiplicand/dividend/move source.
REQ-007 b  in  WIDTH  multiplier/divisor.
REQ-008 busy  out  1  high while an iterative operation is in flight; the pipeline stalls on it.
REQ-009 done  out  1  one-cycle pulse when HI/LO hold the new result.
REQ-010 hi  out  WIDTH  HI register (product upper word / remainder).
REQ-011 lo  out  WIDTH  LO register (product lower word / quotient).
REQ-012 dz  out  1  sticky divide-by-zero flag; cleared by the next accepted start.

Function
REQ-013 States SHALL be IDLE, MUL, DIV, FIX, DONE.
REQ-014 IDLE + start + op 0/1 SHALL go to MUL; op 2/3 SHALL go to DIV; op 4/5 SHALL write a to HI/LO on that edge and stay in IDLE, with no busy and no done.
REQ-015 Reserved op SHALL be ignored, with no state or register change.
REQ-016 MUL SHALL do shift-add and DIV restoring division, one bit per cycle for exactly 32 cycles under a 5-bit counter, then go to FIX.
REQ-017 FIX SHALL apply sign correction (signed ops) and load HI/LO, then go to DONE; DONE SHALL last one cycle, then return to IDLE.
REQ-018 If start is accepted at edge N, done SHALL be high in the cycle after edge N+34 only.
REQ-019 busy SHALL be high from edge N+1 through the DONE cycle inclusive.
REQ-020 HI/LO SHALL NOT change between acceptance and FIX; they hold their old values while busy.
REQ-021 start while busy SHALL be ignored and not queued.
REQ-022 Operands SHALL be latched at acceptance; later changes to a/b SHALL have no effect.
REQ-023 Divide by zero (b==0) SHALL still take the full latency and give HI=a, LO=32'hFFFFFFFF, dz=1.
REQ-024 Signed divide: the quotient sign SHALL be sign(a) XOR sign(b) and the remainder sign SHALL be sign(a).
REQ-025 Signed divide 0x80000000 / -1 SHALL give LO=0x80000000, HI=0.
REQ-026 Multiply SHALL produce the full 64-bit product {HI,LO}.

Reset
REQ-027 reset low at an edge SHALL force IDLE and clear hi, lo, counter, busy, done and dz, including mid-operation; the in-flight result SHALL be discarded.
REQ-028 A start coincident with reset low SHALL be ignored.

Configuration
REQ-029 With MDU_SIGNED_EN defined, ops 1 and 3 SHALL perform signed arithmetic, with an operand-magnitude pre-step at acceptance and the sign fix in FIX.
REQ-030 Without MDU_SIGNED_EN, ops 1 and 3 SHALL behave exactly as ops 0 and 2, and the sign logic SHALL be absent.

Structure
REQ-031 A shared package SHALL hold the op encoding enum (mdu_op_t), the state enum (mdu_state_t) and the constant MDU_ITERATIONS=32.
REQ-032 One sub-module, mdu_shift_core, SHALL hold the shared 64-bit accumulator and the add/subtract step used by both MUL and DIV; the FSM and counter SHALL stay in mdu_sequencer.

Verification
REQ-033 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done 34 cycles after start; HI=0xFFFFFFFE, LO=0x00000001; busy high for 34 cycles.
REQ-034 DIV a=-7, b=2 (signed build) -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); unsigned build -> LO=0x7FFFFFFC, HI=1.
REQ-035 DIVU a=100, b=0 -> HI=100, LO=0xFFFFFFFF, dz=1; next MTLO a=5 -> LO=5, dz=0, no done.
REQ-036 MULT 3*4 started, start re-pulsed at cycle 10 with DIVU 9/3 -> single done at cycle 34; HI=0, LO=12.
REQ-037 DIVU 50/7 started, reset low at cycle 20 -> cycle 21: busy=0, hi=lo=0, no done ever.
REQ-038 MTHI a=0x1234 followed immediately by MULTU 2*3 -> HI=0x1234 while busy, then HI=0, LO=6 at done.
